// File: rtl/output_display_module_pkg.sv
// Shared constants for the output display: FSM encodings, digit codes and 7-segment patterns.
package output_display_module_pkg;

  localparam logic [1:0] DISP_IDLE    = 2'd0;
  localparam logic [1:0] DISP_CONVERT = 2'd1;
  localparam logic [1:0] DISP_COMMIT  = 2'd2;

  // Digit codes: 0-9 are decimal values, the rest are symbols.
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_MINUS = 4'hA;
  localparam digit_t DIG_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input digit_t code);
    logic [6:0] s;
    case (code)
      4'd0:      s = SEG_0;
      4'd1:      s = SEG_1;
      4'd2:      s = SEG_2;
      4'd3:      s = SEG_3;
      4'd4:      s = SEG_4;
      4'd5:      s = SEG_5;
      4'd6:      s = SEG_6;
      4'd7:      s = SEG_7;
      4'd8:      s = SEG_8;
      4'd9:      s = SEG_9;
      DIG_MINUS: s = SEG_MINUS;
      default:   s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/output_display_module_bin_to_bcd.sv
// Sequential 8-bit to 3-digit BCD converter (double-dabble), one shift per cycle.
module bin_to_bcd_module
  import output_display_module_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  operand_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  logic [19:0] sr_q, sr_d, adj;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8+4*i +: 4] >= 4'd5) adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
    end
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sr_d  = {12'd0, operand_i};
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      sr_d  = adj << 1;
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // done marks the cycle of the final shift; bcd_o is valid right after that edge.
  assign done_o = (cnt_q == 4'd1);
  assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/output_display_module.sv
// Output register display: loads a value, converts to BCD, commits atomically, and scans 4 digits.
module output_display_module
  import output_display_module_pkg::*;
#(
  parameter int REFRESH_DIV  = 16,
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ie,
  input  logic       signed_mode,
  input  logic [7:0] data,
  output logic [6:0] seg,
  output logic [3:0] dig,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]       state_q, state_d;
  logic             pendValid_q, pendValid_d;
  logic             pendNeg_q, pendNeg_d;
  logic [7:0]       pendMag_q, pendMag_d;
  logic             curNeg_q, curNeg_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [CW-1:0]    refCnt_q, refCnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;

  logic             inNeg, startNeg, start, convDone;
  logic [7:0]       inMag, startMag;
  logic [11:0]      bcd;
  logic [3:0]       hund, tens, units;

  assign inNeg = signed_mode & data[7];
  assign inMag = inNeg ? (~data + 8'd1) : data;

  bin_to_bcd_module u_bcd (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .operand_i (startMag),
    .done_o    (convDone),
    .bcd_o     (bcd)
  );

  assign hund  = bcd[11:8];
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

  // A load arriving in COMMIT is the newest value, so it wins over an older pending one.
  always_comb begin
    state_d     = state_q;
    pendValid_d = pendValid_q;
    pendNeg_d   = pendNeg_q;
    pendMag_d   = pendMag_q;
    digits_d    = digits_q;
    start       = 1'b0;
    startNeg    = inNeg;
    startMag    = inMag;
    case (state_q)
      DISP_IDLE: begin
        if (ie) begin
          start   = 1'b1;
          state_d = DISP_CONVERT;
        end
      end
      DISP_CONVERT: begin
        if (ie) begin
          pendValid_d = 1'b1;
          pendNeg_d   = inNeg;
          pendMag_d   = inMag;
        end
        if (convDone) state_d = DISP_COMMIT;
      end
      DISP_COMMIT: begin
        digits_d[3] = curNeg_q ? DIG_MINUS : DIG_BLANK;
        digits_d[2] = (hund == 4'd0) ? DIG_BLANK : hund;
        digits_d[1] = (hund == 4'd0 && tens == 4'd0) ? DIG_BLANK : tens;
        digits_d[0] = units;
        pendValid_d = 1'b0;
        if (ie) begin
          start   = 1'b1;
          state_d = DISP_CONVERT;
        end else if (pendValid_q) begin
          start    = 1'b1;
          startNeg = pendNeg_q;
          startMag = pendMag_q;
          state_d  = DISP_CONVERT;
        end else begin
          state_d = DISP_IDLE;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  assign curNeg_d = start ? startNeg : curNeg_q;

  // Scan uses the next index so dig/seg registers line up with the counter wrap.
  always_comb begin
    refCnt_d = refCnt_q + 1'b1;
    idx_d    = idx_q;
    if (refCnt_q == CW'(REFRESH_DIV - 1)) begin
      refCnt_d = '0;
      idx_d    = idx_q + 2'd1;
    end
    seg_d = seg_encode(digits_q[idx_d]);
    dig_d = 4'b0001 << idx_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DISP_IDLE;
      pendValid_q <= 1'b0;
      pendNeg_q   <= 1'b0;
      pendMag_q   <= '0;
      curNeg_q    <= 1'b0;
      digits_q    <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
      refCnt_q    <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_0;
      dig_q       <= 4'b0001;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      pendNeg_q   <= pendNeg_d;
      pendMag_q   <= pendMag_d;
      curNeg_q    <= curNeg_d;
      digits_q    <= digits_d;
      refCnt_q    <= refCnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign busy = (state_q != DISP_IDLE);
  assign seg  = (COMMON_ANODE != 0) ? ~seg_q : seg_q;
  assign dig  = (COMMON_ANODE != 0) ? ~dig_q : dig_q;

endmodule
